// File: rtl/qspi_flash_target.sv
// QSPI (4-bit) flash target: oversamples the pins in the clk domain and serves
// 0xEB reads / 0x38 writes from a word-addressed memory port.
module qspi_flash_target #(
  parameter int ADDR_W       = 16,
  parameter int DUMMY_CYCLES = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              qspi_ck_i,
  input  logic              qspi_cs_i,
  input  logic [3:0]        qspi_io_i,
  output logic [3:0]        qspi_io_o,
  output logic              qspi_io_t,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              underrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RD_DATA, S_WR_DATA, S_WR_FLUSH, S_IGNORE
  } state_t;

  state_t state_q, state_d;

  // [0]/[1] are the two synchronizer stages, [2] is the previous value for edge detect
  logic [2:0] ck_sync_q, ck_sync_d;
  logic [2:0] cs_sync_q, cs_sync_d;
  logic [3:0] io_s1_q, io_s1_d, io_s2_q, io_s2_d;

  logic [7:0]        cnt_q, cnt_d;
  logic [19:0]       sh_q, sh_d;
  logic              is_rd_q, is_rd_d;
  logic [ADDR_W-1:0] word_q, word_d;
  logic [1:0]        byte_q, byte_d;
  logic              nib_q, nib_d;
  logic [3:0]        hold_q, hold_d;
  logic [3:0]        out_lo_q, out_lo_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_issue_q, rd_issue_d;
  logic              stale_q, stale_d;
  logic [31:0]       wbuf_q, wbuf_d;
  logic [3:0]        wbe_q, wbe_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [3:0]        io_o_q, io_o_d;
  logic              io_t_q, io_t_d;
  logic              underrun_q, underrun_d;

  logic        cs_rise, cs_fall, sck_rise, sck_fall;
  logic [23:0] addr24;
  logic [7:0]  wr_byte;
  logic [7:0]  rd_byte;
  logic [31:0] wbuf_nx;
  logic [3:0]  wbe_nx;

  // CS rise wins over a coincident SCK edge, so the SCK pulses are masked by it
  assign cs_rise  =  cs_sync_q[1] & ~cs_sync_q[2];
  assign cs_fall  = ~cs_sync_q[1] &  cs_sync_q[2];
  assign sck_rise =  ck_sync_q[1] & ~ck_sync_q[2] & ~cs_rise;
  assign sck_fall = ~ck_sync_q[1] &  ck_sync_q[2] & ~cs_rise;
  assign addr24   = {sh_q, io_s2_q};
  assign wr_byte  = {hold_q, io_s2_q};
  assign rd_byte  = rd_data_q[{byte_q, 3'b000} +: 8];

  always_comb begin
    ck_sync_d   = {ck_sync_q[1:0], qspi_ck_i};
    cs_sync_d   = {cs_sync_q[1:0], qspi_cs_i};
    io_s1_d     = qspi_io_i;
    io_s2_d     = io_s1_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    is_rd_d     = is_rd_q;
    word_d      = word_q;
    byte_d      = byte_q;
    nib_d       = nib_q;
    hold_d      = hold_q;
    out_lo_d    = out_lo_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_valid_q;
    rd_issue_d  = rd_issue_q;
    stale_d     = stale_q;
    wbuf_d      = wbuf_q;
    wbe_d       = wbe_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    io_o_d      = io_o_q;
    io_t_d      = io_t_q;
    underrun_d  = underrun_q;
    wbuf_nx     = wbuf_q;
    wbe_nx      = wbe_q;

    // A response to a read launched by an aborted transfer is dropped
    if (mem_req_q && mem_ready) begin
      mem_req_d = 1'b0;
      stale_d   = 1'b0;
      if (!mem_we_q && !stale_q) begin
        rd_data_d  = mem_rdata;
        rd_valid_d = 1'b1;
      end
    end

    if (rd_issue_q && !mem_req_q) begin
      mem_req_d  = 1'b1;
      mem_we_d   = 1'b0;
      mem_addr_d = word_q;
      rd_issue_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        io_t_d = 1'b1;
        if (cs_fall) begin
          state_d    = S_CMD;
          cnt_d      = '0;
          nib_d      = 1'b0;
          underrun_d = 1'b0;
          wbuf_d     = '0;
          wbe_d      = '0;
          rd_valid_d = 1'b0;
          rd_issue_d = 1'b0;
        end
      end
      S_CMD: begin
        if (sck_rise) begin
          sh_d  = {sh_q[15:0], io_s2_q};
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd1) begin
            cnt_d = '0;
            if ({sh_q[3:0], io_s2_q} == 8'hEB) begin
              is_rd_d = 1'b1;
              state_d = S_ADDR;
            end else if ({sh_q[3:0], io_s2_q} == 8'h38) begin
              is_rd_d = 1'b0;
              state_d = S_ADDR;
            end else begin
              state_d = S_IGNORE;
            end
          end
        end
      end
      S_ADDR: begin
        if (sck_rise) begin
          sh_d  = {sh_q[15:0], io_s2_q};
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd5) begin
            cnt_d  = '0;
            word_d = ADDR_W'(addr24 >> 2);
            byte_d = io_s2_q[1:0];
            nib_d  = 1'b0;
            if (is_rd_q) begin
              rd_valid_d = 1'b0;
              rd_issue_d = 1'b1;
              state_d    = (DUMMY_CYCLES == 0) ? S_RD_DATA : S_DUMMY;
            end else begin
              wbuf_d  = '0;
              wbe_d   = '0;
              state_d = S_WR_DATA;
            end
          end
        end
      end
      S_DUMMY: begin
        if (sck_rise) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'(DUMMY_CYCLES - 1)) begin
            state_d = S_RD_DATA;
          end
        end
      end
      S_RD_DATA: begin
        if (sck_fall) begin
          io_t_d = 1'b0;
          if (!nib_q) begin
            // Byte start: stall on 0xF until the word is present
            if (rd_valid_q) begin
              io_o_d   = rd_byte[7:4];
              out_lo_d = rd_byte[3:0];
              nib_d    = 1'b1;
              if (byte_q == 2'd3) begin
                rd_valid_d = 1'b0;
                rd_issue_d = 1'b1;
                word_d     = word_q + ADDR_W'(1);
              end
            end else begin
              io_o_d     = 4'hF;
              underrun_d = 1'b1;
            end
          end else begin
            io_o_d = out_lo_q;
            nib_d  = 1'b0;
            byte_d = byte_q + 2'd1;
          end
        end
      end
      S_WR_DATA: begin
        if (sck_rise) begin
          if (!nib_q) begin
            hold_d = io_s2_q;
            nib_d  = 1'b1;
          end else begin
            nib_d  = 1'b0;
            byte_d = byte_q + 2'd1;
            if (byte_q == 2'd3) begin
              word_d = word_q + ADDR_W'(1);
            end
            if (mem_req_q) begin
              underrun_d = 1'b1;
              if (byte_q == 2'd3) begin
                wbuf_d = '0;
                wbe_d  = '0;
              end
            end else begin
              for (int k = 0; k < 4; k++) begin
                if (byte_q == 2'(k)) begin
                  wbuf_nx[8*k +: 8] = wr_byte;
                  wbe_nx[k]         = 1'b1;
                end
              end
              if (byte_q == 2'd3) begin
                mem_req_d   = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = word_q;
                mem_wdata_d = wbuf_nx;
                mem_be_d    = wbe_nx;
                wbuf_d      = '0;
                wbe_d       = '0;
              end else begin
                wbuf_d = wbuf_nx;
                wbe_d  = wbe_nx;
              end
            end
          end
        end
      end
      S_WR_FLUSH: begin
        if (!mem_req_q) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = word_q;
          mem_wdata_d = wbuf_q;
          mem_be_d    = wbe_q;
          wbuf_d      = '0;
          wbe_d       = '0;
          state_d     = S_IDLE;
        end
      end
      default: ;
    endcase

    if (cs_rise && state_q != S_IDLE && state_q != S_WR_FLUSH) begin
      io_t_d     = 1'b1;
      io_o_d     = 4'h0;
      rd_issue_d = 1'b0;
      nib_d      = 1'b0;
      stale_d    = mem_req_d && !mem_we_d;
      state_d    = (state_q == S_WR_DATA && wbe_q != 4'h0) ? S_WR_FLUSH : S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ck_sync_q   <= 3'b000;
      cs_sync_q   <= 3'b111;
      io_s1_q     <= '0;
      io_s2_q     <= '0;
      cnt_q       <= '0;
      sh_q        <= '0;
      is_rd_q     <= 1'b0;
      word_q      <= '0;
      byte_q      <= '0;
      nib_q       <= 1'b0;
      hold_q      <= '0;
      out_lo_q    <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_issue_q  <= 1'b0;
      stale_q     <= 1'b0;
      wbuf_q      <= '0;
      wbe_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      io_o_q      <= '0;
      io_t_q      <= 1'b1;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ck_sync_q   <= ck_sync_d;
      cs_sync_q   <= cs_sync_d;
      io_s1_q     <= io_s1_d;
      io_s2_q     <= io_s2_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      is_rd_q     <= is_rd_d;
      word_q      <= word_d;
      byte_q      <= byte_d;
      nib_q       <= nib_d;
      hold_q      <= hold_d;
      out_lo_q    <= out_lo_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      rd_issue_q  <= rd_issue_d;
      stale_q     <= stale_d;
      wbuf_q      <= wbuf_d;
      wbe_q       <= wbe_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      io_o_q      <= io_o_d;
      io_t_q      <= io_t_d;
      underrun_q  <= underrun_d;
    end
  end

  assign qspi_io_o = io_o_q;
  assign qspi_io_t = io_t_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign underrun  = underrun_q;

endmodule
